// File: rtl/fetch_queue.sv
// Instruction fetch queue: walks a 64-bit fetch pointer, reads one tetra per memory request
// and buffers {loc, inst, px, f} entries for the consumer; address faults become SWYM entries.
module fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     redirect,
    input  logic [63:0]              redirect_addr,
    input  logic                     deq,
    output logic                     head_valid,
    output logic [63:0]              head_loc,
    output logic [31:0]              head_inst,
    output logic                     head_px,
    output logic                     head_f,
    output logic [$clog2(DEPTH):0]   count,
    output logic [63:0]              mem_address,
    output logic [1:0]               mem_datasize,
    output logic                     mem_read,
    input  logic [63:0]              mem_readdata,
    input  logic                     mem_done
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [31:0] SWYM = 32'hFD00_0000;
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {IDLE, CHECK, READ, DRAIN, HALT} state_t;

    state_t          state;
    logic [63:0]     fptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;

    logic [63:0]     loc_q  [DEPTH];
    logic [31:0]     inst_q [DEPTH];
    logic            px_q   [DEPTH];
    logic            f_q    [DEPTH];

    logic            deq_fire;
    logic            room;
    logic            enq;
    logic [31:0]     enq_inst;
    logic            enq_px;
    logic            enq_f;
    logic [63:0]     new_fptr;
    logic            unused_bits;

    assign unused_bits = ^{mem_readdata[63:32], fptr[1:0], fptr[63]};

    assign deq_fire     = deq && head_valid;
    // A pop in the same cycle frees a slot, so a full buffer can still accept
    assign room         = (count != FULL) || deq_fire;
    assign new_fptr     = {redirect_addr[63:2], 2'b00};

    assign head_valid   = (count != '0);
    assign head_loc     = loc_q[rd_ptr];
    assign head_inst    = inst_q[rd_ptr];
    assign head_px      = px_q[rd_ptr];
    assign head_f       = f_q[rd_ptr];
    assign mem_address  = {1'b0, fptr[62:2], 2'b00};
    assign mem_datasize = 2'b10;

    always_comb begin
        enq      = 1'b0;
        enq_inst = SWYM;
        enq_px   = 1'b0;
        enq_f    = 1'b0;
        if (!redirect) begin
            case (state)
                CHECK: begin
                    if (room && (!fptr[63] || (fptr[62:48] != 15'd0))) begin
                        enq    = 1'b1;
                        enq_px = fptr[63];
                        enq_f  = !fptr[63];
                    end
                end
                READ: begin
                    if (mem_done) begin
                        enq      = 1'b1;
                        enq_inst = mem_readdata[31:0];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            loc_q[wr_ptr]  <= fptr;
            inst_q[wr_ptr] <= enq_inst;
            px_q[wr_ptr]   <= enq_px;
            f_q[wr_ptr]    <= enq_f;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            fptr     <= '0;
            mem_read <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            fptr   <= new_fptr;
            case (state)
                // An outstanding read must still be completed by memory before refetching
                READ, DRAIN: begin
                    if (mem_done) begin
                        mem_read <= 1'b0;
                        state    <= CHECK;
                    end else begin
                        state    <= DRAIN;
                    end
                end
                default: state <= CHECK;
            endcase
        end else begin
            if (enq)      wr_ptr <= wr_ptr + 1'b1;
            if (deq_fire) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, enq} - {{AW{1'b0}}, deq_fire};
            case (state)
                CHECK: begin
                    if (room) begin
                        if (enq) begin
                            state <= HALT;
                        end else begin
                            mem_read <= 1'b1;
                            state    <= READ;
                        end
                    end
                end
                READ: begin
                    if (mem_done) begin
                        mem_read <= 1'b0;
                        fptr     <= fptr + 64'd4;
                        state    <= CHECK;
                    end
                end
                DRAIN: begin
                    if (mem_done) begin
                        mem_read <= 1'b0;
                        state    <= CHECK;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a stream-level model predicts each head entry from
// the redirect address, while a randomized memory answers reads with address-derived data.
module tb_fetch_queue;
    localparam int DEPTH = 4;
    localparam logic [31:0] SWYM = 32'hFD00_0000;

    logic                   clk = 1'b0;
    logic                   reset_n = 1'b0;
    logic                   redirect = 1'b0;
    logic [63:0]            redirect_addr = '0;
    logic                   deq = 1'b0;
    logic                   head_valid;
    logic [63:0]            head_loc;
    logic [31:0]            head_inst;
    logic                   head_px;
    logic                   head_f;
    logic [$clog2(DEPTH):0] count;
    logic [63:0]            mem_address;
    logic [1:0]             mem_datasize;
    logic                   mem_read;
    logic [63:0]            mem_readdata = '0;
    logic                   mem_done = 1'b0;

    logic        hold_mem = 1'b0;
    logic        fast_mem = 1'b0;
    logic        dead_mode = 1'b0;
    int          checks = 0;
    int          errors = 0;
    logic [63:0] m_head = '0;
    logic        m_ended = 1'b1;
    logic        saw_read = 1'b0;

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .redirect(redirect), .redirect_addr(redirect_addr),
        .deq(deq), .head_valid(head_valid), .head_loc(head_loc), .head_inst(head_inst),
        .head_px(head_px), .head_f(head_f), .count(count), .mem_address(mem_address),
        .mem_datasize(mem_datasize), .mem_read(mem_read), .mem_readdata(mem_readdata),
        .mem_done(mem_done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [63:0] a);
        logic [31:0] t;
        t = a[31:0] - 32'h100;
        return 32'hA1 + (t >> 2);
    endfunction

    function automatic logic is_fault(input logic [63:0] a);
        return !a[63] || (a[62:48] != 15'd0);
    endfunction

    function automatic logic [97:0] entry_of(input logic [63:0] a);
        if (!a[63]) return {a, SWYM, 1'b0, 1'b1};
        if (a[62:48] != 15'd0) return {a, SWYM, 1'b1, 1'b0};
        return {a, memf(a), 2'b00};
    endfunction

    // Memory model: one-cycle done pulse after a random (or immediate) wait
    initial forever begin
        @(negedge clk);
        #1;
        if (mem_done) begin
            mem_done = 1'b0;
        end else if (mem_read && !hold_mem && (fast_mem || $urandom_range(0, 2) == 0)) begin
            mem_readdata = dead_mode ? 64'hDEAD : {$urandom(), memf(mem_address)};
            mem_done = 1'b1;
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: check head against the stream model, drive inputs, advance the model
    task automatic step(input logic d, input logic r, input logic [63:0] a);
        logic hv;
        hv = head_valid;
        if (hv) begin
            check("extra_entry", m_ended, 1'b0);
            if (!m_ended)
                check("head_entry", {head_loc, head_inst, head_px, head_f}, entry_of(m_head));
        end
        check("valid_vs_count", head_valid, count != 0);
        check("count_max", count <= DEPTH, 1'b1);
        if (mem_read) begin
            saw_read = 1'b1;
            check("mem_fmt", {mem_address[63], mem_address[1:0], mem_datasize}, 5'b000_10);
        end
        deq = d;
        redirect = r;
        redirect_addr = a;
        @(posedge clk);
        if (r) begin
            m_head = {a[63:2], 2'b00};
            m_ended = 1'b0;
        end else if (d && hv) begin
            if (is_fault(m_head)) m_ended = 1'b1;
            else m_head = m_head + 64'd4;
        end
        @(negedge clk);
        deq = 1'b0;
        redirect = 1'b0;
    endtask

    task automatic wait_read(input string tag);
        for (int i = 0; i < 100 && !mem_read; i++) step(1'b0, 1'b0, '0);
        check(tag, mem_read, 1'b1);
    endtask

    task automatic wait_count(input string tag, input int n);
        for (int i = 0; i < 400 && count < n; i++) step(1'b0, 1'b0, '0);
        check(tag, count >= n, 1'b1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_valid", head_valid, 1'b0);
        check("rst_count", count, 0);
        check("rst_read", mem_read, 1'b0);
        check("rst_addr", mem_address, 64'h0);
        check("rst_size", mem_datasize, 2'b10);
        reset_n = 1'b1;

        saw_read = 1'b0;
        repeat (5) step(1'b0, 1'b0, '0);
        check("idle_no_read", saw_read, 1'b0);
        check("idle_empty", count, 0);

        // Translation fault: pointer with bit 63 clear
        saw_read = 1'b0;
        step(1'b0, 1'b1, 64'h0000_0000_0000_1000);
        repeat (8) step(1'b0, 1'b0, '0);
        check("f_count", count, 1);
        check("f_head", {head_f, head_px, head_inst}, {2'b10, SWYM});
        step(1'b1, 1'b0, '0);
        repeat (5) step(1'b0, 1'b0, '0);
        check("f_halt_empty", count, 0);
        check("f_no_read", saw_read, 1'b0);

        // Protection fault: high address bits set
        saw_read = 1'b0;
        step(1'b0, 1'b1, 64'h8001_0000_0000_0000);
        repeat (8) step(1'b0, 1'b0, '0);
        check("px_count", count, 1);
        check("px_head", {head_f, head_px, head_inst}, {2'b01, SWYM});
        check("px_no_read", saw_read, 1'b0);

        // Normal fill with no consumer
        step(1'b0, 1'b1, 64'h8000_0000_0000_0100);
        wait_count("fill_wait", DEPTH);
        check("fill_count", count, 4);
        check("fill_loc", head_loc, 64'h8000_0000_0000_0100);
        check("fill_inst", head_inst, 32'hA1);
        saw_read = 1'b0;
        repeat (6) step(1'b0, 1'b0, '0);
        check("full_no_read", saw_read, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("drain_inst", head_inst, 32'hA1 + i);
            step(1'b1, 1'b0, '0);
        end

        // Pointer walks across the 48-bit boundary; low redirect bits ignored
        step(1'b0, 1'b1, 64'h8000_FFFF_FFFF_FFFB);
        wait_count("bnd_wait", 3);
        repeat (5) step(1'b0, 1'b0, '0);
        check("bnd_count", count, 3);
        check("bnd_lowbits", head_loc, 64'h8000_FFFF_FFFF_FFF8);
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        check("bnd_px", {head_loc, head_px, head_inst}, {64'h8001_0000_0000_0000, 1'b1, SWYM});
        step(1'b1, 1'b0, '0);
        repeat (3) step(1'b0, 1'b0, '0);
        check("bnd_empty", count, 0);

        // Back-to-back memory: latency and throughput, then streaming pops
        fast_mem = 1'b1;
        step(1'b0, 1'b1, 64'h8000_0000_0000_4000);
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        check("first_latency", count, 1);
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        check("tetra_rate", count, 2);
        wait_count("stream_full", DEPTH);
        repeat (3) step(1'b0, 1'b0, '0);
        check("full_waits", mem_read, 1'b0);
        step(1'b1, 1'b0, '0);
        check("deq_frees_slot", mem_read, 1'b1);
        repeat (40) step(1'b1, 1'b0, '0);

        // Redirect during an outstanding read; stale data must be dropped
        hold_mem = 1'b1;
        step(1'b0, 1'b1, 64'h8000_0000_0000_2000);
        wait_read("dead_read1");
        step(1'b0, 1'b1, 64'h8000_0000_0000_3000);
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        check("drain_hold", {mem_read, count}, {1'b1, 3'd0});
        dead_mode = 1'b1;
        hold_mem = 1'b0;
        step(1'b0, 1'b0, '0);
        dead_mode = 1'b0;
        check("drain_done", {mem_read, count}, {1'b0, 3'd0});
        wait_read("dead_read2");
        check("next_addr", mem_address, 64'h0000_0000_0000_3000);
        wait_count("dead_refill", 1);
        check("dead_head", {head_loc, head_inst}, {64'h8000_0000_0000_3000, memf(64'h3000)});
        fast_mem = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [63:0] a;
            case ($urandom_range(0, 3))
                0: a = {32'h8000_0000, $urandom()};
                1: a = 64'h8000_FFFF_FFFF_FFE0 | 64'($urandom_range(0, 31));
                2: a = {1'b0, 31'($urandom()), $urandom()};
                default: a = {32'h8123_0000 | 32'($urandom_range(0, 255)), $urandom()};
            endcase
            step(1'($urandom_range(0, 1)), $urandom_range(0, 19) == 0, a);
        end

        // Asynchronous reset in the middle of a read
        fast_mem = 1'b1;
        step(1'b0, 1'b1, 64'h8000_0000_0000_5000);
        wait_count("pre_rst_fill", 2);
        hold_mem = 1'b1;
        wait_read("pre_rst_read");
        check("pre_rst_count", count != 0, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_read", mem_read, 1'b0);
        check("arst_valid", head_valid, 1'b0);
        check("arst_count", count, 0);
        m_ended = 1'b1;
        hold_mem = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        saw_read = 1'b0;
        repeat (10) step(1'b0, 1'b0, '0);
        check("post_rst_no_read", saw_read, 1'b0);
        check("post_rst_empty", count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
